// File: rtl/ram2_arb_if.sv
// Client-side bundle of the shared RAM2 model: fetch port plus data port.
// The RAM model takes the slave modport, the IF/MEM side the master.
interface ram2_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_valid;
    logic              mem_ce;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_done;
    logic              stall_req;
    logic              wprot_err;

    modport master (
        output pc,
        output mem_ce,
        output mem_re,
        output mem_we,
        output mem_addr_i,
        output mem_data_i,
        input  inst_o,
        input  inst_pc_o,
        input  inst_valid,
        input  mem_data_o,
        input  mem_done,
        input  stall_req,
        input  wprot_err
    );

    modport slave (
        input  pc,
        input  mem_ce,
        input  mem_re,
        input  mem_we,
        input  mem_addr_i,
        input  mem_data_i,
        output inst_o,
        output inst_pc_o,
        output inst_valid,
        output mem_data_o,
        output mem_done,
        output stall_req,
        output wprot_err
    );
endinterface

// File: rtl/ram2_arb_model.sv
// Shared RAM2 model: one array for fetch and data, data port wins, fixed latency.
// Define RAM2_WPROT_EN to drop writes to word indices below PROT_LIMIT.
module ram2_arb_model #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                DEPTH_LOG2  = 12,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] NOP_INST    = 16'h0800,
    parameter int                PROT_LIMIT  = 64
) (
    input logic       clk,
    input logic       rst,
    ram2_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        INST,
        DONE
    } state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_t                state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     wdata;
    logic [ADDR_W-1:0]     fetch_pc;
    logic                  we_q;
    logic                  werr_q;
    logic                  dreq;
    logic                  last;
    logic                  blocked;
    logic                  ram_wr;
    logic [DATA_W-1:0]     ram [DEPTH];

    assign dreq = bus.mem_ce & (bus.mem_re | bus.mem_we);
    assign last = (cnt == 4'd0);

    // A pending data request stalls the pipe even while a fetch drains.
    assign bus.stall_req = (state == DATA)
                         | (((state == IDLE) | (state == INST)) & dreq);

`ifdef RAM2_WPROT_EN
    assign blocked = (32'(idx) < PROT_LIMIT);
`else
    logic unused_prot;
    assign blocked     = 1'b0;
    assign unused_prot = (PROT_LIMIT != 0);
`endif

    assign bus.wprot_err = werr_q;

    logic unused_addr;
    assign unused_addr = ^bus.mem_addr_i[ADDR_W-1:DEPTH_LOG2];

    // Array is not reset; a write lands only in the final access cycle.
    assign ram_wr = ~rst & (state == DATA) & last & we_q & ~blocked;

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            idx            <= '0;
            wdata          <= '0;
            fetch_pc       <= '0;
            we_q           <= 1'b0;
            werr_q         <= 1'b0;
            bus.inst_o     <= NOP_INST;
            bus.inst_pc_o  <= '0;
            bus.inst_valid <= 1'b0;
            bus.mem_data_o <= '0;
            bus.mem_done   <= 1'b0;
        end else begin
            bus.inst_valid <= 1'b0;
            bus.mem_done   <= 1'b0;
            werr_q         <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= 4'(WAIT_CYCLES);
                    if (dreq) begin
                        state <= DATA;
                        idx   <= bus.mem_addr_i[DEPTH_LOG2-1:0];
                        wdata <= bus.mem_data_i;
                        we_q  <= bus.mem_we;
                    end else begin
                        state    <= INST;
                        idx      <= bus.pc[DEPTH_LOG2-1:0];
                        fetch_pc <= bus.pc;
                    end
                end
                DATA: begin
                    if (!last) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state        <= DONE;
                        bus.mem_done <= 1'b1;
                        if (we_q) begin
                            werr_q <= blocked;
                        end else begin
                            bus.mem_data_o <= ram[idx];
                        end
                    end
                end
                INST: begin
                    if (!last) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state          <= DONE;
                        bus.inst_valid <= 1'b1;
                        bus.inst_o     <= ram[idx];
                        bus.inst_pc_o  <= fetch_pc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram2_arb_model.sv
// Random client traffic against a timestamp-based model of the shared RAM2,
// plus directed scenarios with literal expectations.
module tb_ram2_arb_model;
    localparam int W     = 1;
    localparam int DL    = 12;
    localparam int DEPTH = 1 << DL;
`ifdef RAM2_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram2_arb_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    ram2_arb_model #(
        .DATA_W     (16),
        .ADDR_W     (16),
        .DEPTH_LOG2 (DL),
        .WAIT_CYCLES(W),
        .NOP_INST   (16'h0800),
        .PROT_LIMIT (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int dcount = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Model: each access is a transaction with a start edge,
    // a completion edge and the first edge free for a new one.
    logic [15:0] mram [DEPTH];
    bit          mknown [DEPTH];
    int          ecnt   = 0;
    int          t_done = -10;
    int          t_free = 0;
    bit          armed  = 0;
    bit          m_is_data;
    bit          m_we;
    int          m_idx;
    logic [15:0] m_wd, m_pc;
    logic [15:0] m_inst, m_ipc, m_data;
    bit          m_valid, m_done, m_werr;
    bit          inst_known, data_known;

    task automatic model_step();
        int k;
        bit dr;
        ecnt++;
        k = ecnt;
        m_valid = 0;
        m_done  = 0;
        m_werr  = 0;
        if (rst) begin
            armed      = 1;
            m_inst     = 16'h0800;
            m_ipc      = 0;
            m_data     = 0;
            inst_known = 1;
            data_known = 1;
            t_done     = -10;
            t_free     = k + 1;
        end else if (k == t_done) begin
            if (m_is_data) begin
                m_done = 1;
                if (m_we) begin
                    if (WPROT && m_idx < 64) begin
                        m_werr = 1;
                    end else begin
                        mram[m_idx]   = m_wd;
                        mknown[m_idx] = 1;
                    end
                end else begin
                    m_data     = mram[m_idx];
                    data_known = mknown[m_idx];
                end
            end else begin
                m_valid    = 1;
                m_inst     = mram[m_idx];
                inst_known = mknown[m_idx];
                m_ipc      = m_pc;
            end
        end else if (k >= t_free) begin
            dr = bus.mem_ce & (bus.mem_re | bus.mem_we);
            m_is_data = dr;
            if (dr) begin
                m_idx = int'(bus.mem_addr_i) % DEPTH;
                m_wd  = bus.mem_data_i;
                m_we  = bus.mem_we;
            end else begin
                m_idx = int'(bus.pc) % DEPTH;
                m_pc  = bus.pc;
            end
            t_done = k + 1 + W;
            t_free = k + 3 + W;
        end
    endtask

    function automatic bit m_idle();
        return (ecnt + 1 >= t_free);
    endfunction

    function automatic bit m_inflight();
        return !m_idle() && (ecnt < t_done);
    endfunction

    function automatic bit m_stall();
        bit dr;
        dr = bus.mem_ce & (bus.mem_re | bus.mem_we);
        return (m_inflight() && m_is_data)
             || ((m_idle() || (m_inflight() && !m_is_data)) && dr);
    endfunction

    always begin
        @(posedge clk);
        model_step();
        #1;
        if (armed) begin
            chk("inst_valid", bus.inst_valid, m_valid);
            chk("mem_done", bus.mem_done, m_done);
            chk("wprot_err", bus.wprot_err, m_werr);
            chk("inst_pc_o", bus.inst_pc_o, m_ipc);
            if (inst_known) chk("inst_o", bus.inst_o, m_inst);
            if (data_known) chk("mem_data_o", bus.mem_data_o, m_data);
        end
        @(negedge clk);
        #2;
        if (armed) chk("stall_req", bus.stall_req, m_stall());
    end

    always @(posedge clk) begin
        #1;
        if (bus.inst_valid === 1'b1) vcount++;
        if (bus.mem_done === 1'b1) dcount++;
    end

    task automatic idle_port();
        bus.mem_ce = 0;
        bus.mem_re = 0;
        bus.mem_we = 0;
    endtask

    // Called at a negedge; returns at the negedge of the mem_done cycle.
    task automatic access(input bit re, input bit we,
                          input logic [15:0] a, input logic [15:0] d);
        int n;
        bus.mem_ce     = 1;
        bus.mem_re     = re;
        bus.mem_we     = we;
        bus.mem_addr_i = a;
        bus.mem_data_i = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_done && n < 50);
        if (!m_done) begin
            errors++;
            $display("FAIL access_timeout got none want done");
        end
        idle_port();
    endtask

    function automatic logic [15:0] rand_addr();
        logic [11:0] lo;
        logic [3:0]  hi;
        lo = 12'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) lo = lo + 12'h100;
        hi = 4'($urandom_range(0, 15));
        return {hi, lo};
    endfunction

    initial begin
        bit found;
        int v0, d0;
        bit req_on;
        bus.pc = 0;
        bus.mem_addr_i = 0;
        bus.mem_data_i = 0;
        idle_port();
        @(negedge clk);
        @(negedge clk);
        chk("rst_inst_o", bus.inst_o, 16'h0800);
        chk("rst_inst_pc", bus.inst_pc_o, 0);
        chk("rst_data_o", bus.mem_data_o, 0);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_done", bus.mem_done, 0);
        rst = 0;

        // Preload words 0..3 through the data port, then restart.
        access(0, 1, 16'h0000, 16'h6911);
        access(0, 1, 16'h0001, 16'h6A22);
        access(0, 1, 16'h0002, 16'h6B33);
        access(0, 1, 16'h0003, 16'hE151);
        bus.pc = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("nop_before_fetch", bus.inst_o, 16'h0800);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) found = 1;
        end
        chk("first_fetch_seen", 32'(found), 1);
`ifndef RAM2_WPROT_EN
        chk("first_inst", bus.inst_o, 16'h6911);
`endif
        chk("first_inst_pc", bus.inst_pc_o, 0);

        // Write then read back; no fetch may slip in between.
        access(0, 1, 16'h0100, 16'h1234);
        v0 = vcount;
        access(1, 0, 16'h0100, 16'h0000);
        chk("rd_after_wr", bus.mem_data_o, 16'h1234);
        chk("no_fetch_between", vcount, v0);
        access(1, 0, 16'hF100, 16'h0000);
        chk("alias_rd", bus.mem_data_o, 16'h1234);

        // Data request raised while a fetch is in flight.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_inflight() && !m_is_data) found = 1;
        end
        chk("fetch_inflight_seen", 32'(found), 1);
        v0 = vcount;
        access(1, 1, 16'h0102, 16'h5555);
        chk("fetch_first", vcount, v0 + 1);
        chk("rw_is_write", bus.mem_data_o, 16'h1234);
        access(1, 0, 16'h0102, 16'h0000);
        chk("rw_written", bus.mem_data_o, 16'h5555);

        // Reset lands one cycle before the write's final cycle.
        rst = 1;
        @(negedge clk);
        rst = 0;
        bus.mem_ce     = 1;
        bus.mem_we     = 1;
        bus.mem_addr_i = 16'h0100;
        bus.mem_data_i = 16'hAAAA;
        @(negedge clk);
        rst = 1;
        d0 = dcount;
        @(negedge clk);
        rst = 0;
        idle_port();
        chk("abort_inst_o", bus.inst_o, 16'h0800);
        chk("abort_inst_pc", bus.inst_pc_o, 0);
        chk("abort_data_o", bus.mem_data_o, 0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", dcount, d0);
        access(1, 0, 16'h0100, 16'h0000);
        chk("abort_kept_old", bus.mem_data_o, 16'h1234);

        // Protected low word versus index 64.
        access(0, 1, 16'd10, 16'hBEEF);
        chk("wprot_lo", 32'(bus.wprot_err), 32'(WPROT));
        access(1, 0, 16'd10, 16'h0000);
`ifndef RAM2_WPROT_EN
        chk("lo_written", bus.mem_data_o, 16'hBEEF);
`endif
        access(0, 1, 16'd64, 16'hBEEF);
        chk("wprot_64", bus.wprot_err, 0);
        access(1, 0, 16'd64, 16'h0000);
        chk("idx64_written", bus.mem_data_o, 16'hBEEF);

        // Random traffic, checked every cycle by the compare process.
        req_on = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            bus.pc = rand_addr();
            if (req_on && m_done) begin
                req_on = 0;
                idle_port();
            end else if (!req_on) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_on         = 1;
                    bus.mem_ce     = 1;
                    bus.mem_we     = 1'($urandom_range(0, 1));
                    bus.mem_re     = !bus.mem_we
                                   || ($urandom_range(0, 3) == 0);
                    bus.mem_addr_i = rand_addr();
                    bus.mem_data_i = 16'($urandom);
                end else begin
                    bus.mem_ce = 0;
                    bus.mem_re = 1'($urandom_range(0, 1));
                    bus.mem_we = 1'($urandom_range(0, 1));
                end
            end
        end
        @(negedge clk);
        rst = 0;
        idle_port();
        repeat (8) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
